// File: rtl/serial_frame_controller_if.sv
// serial_frame_controller_if: serial line, shift-register control and output-word handshake bundle.
interface serial_frame_controller_if;
    logic       serIn;
    logic       sh_in;
    logic       sh_en;
    logic [0:5] sh_q;
    logic [5:0] out_word;
    logic       out_valid;
    logic       out_ready;
    logic       out_perr;
    logic       frame_err;
    logic       overrun;
    modport master (
        input  serIn, sh_q, out_ready,
        output sh_in, sh_en, out_word, out_valid, out_perr, frame_err, overrun
    );
    modport slave (
        output serIn, sh_q, out_ready,
        input  sh_in, sh_en, out_word, out_valid, out_perr, frame_err, overrun
    );
endinterface

// File: rtl/serial_frame_controller.sv
// serial_frame_controller: detects start bits, gates the 6-bit shift register for six bit-times,
// checks parity/stop and hands the captured word downstream over valid/ready.
module serial_frame_controller #(
    parameter int PARITY_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_frame_controller_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
    localparam logic PAR_ON = (PARITY_EN != 0);
    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic       r_perr;
    logic [5:0] r_word;
    logic       r_valid;
    logic       r_out_perr;
    logic       r_ferr;
    logic       r_ovr;
    logic [5:0] w_q;
    logic       w_deliver;
    logic       w_accept;
    // sh_q is declared [0:5]; keep index i of the register at index i of the word
    assign w_q = {bus.sh_q[5], bus.sh_q[4], bus.sh_q[3], bus.sh_q[2], bus.sh_q[1], bus.sh_q[0]};
    assign w_deliver = (r_state == STOP) && bus.serIn;
    assign w_accept  = r_valid && bus.out_ready;
    assign bus.sh_in     = bus.serIn;
    assign bus.sh_en     = (r_state == DATA) && !rst;
    assign bus.out_word  = r_word;
    assign bus.out_valid = r_valid;
    assign bus.out_perr  = r_out_perr;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_perr     <= 1'b0;
            r_word     <= 6'd0;
            r_valid    <= 1'b0;
            r_out_perr <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ferr <= (r_state == STOP) && !bus.serIn;
            r_ovr  <= w_deliver && r_valid && !bus.out_ready;
            case (r_state)
                IDLE: if (!bus.serIn) begin
                    r_state <= DATA;
                    r_cnt   <= 3'd0;
                end
                DATA: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd5) r_state <= PAR_ON ? PARITY : STOP;
                end
                PARITY: begin
                    r_perr  <= ^w_q ^ bus.serIn;
                    r_state <= STOP;
                end
                default: r_state <= IDLE;
            endcase
            // a word held against a stalled consumer is never overwritten
            if (w_deliver && (!r_valid || bus.out_ready)) begin
                r_word     <= w_q;
                r_out_perr <= PAR_ON && r_perr;
                r_valid    <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_controller.sv
// tb_serial_frame_controller: directed frames against a timing/handshake model of the framing rules.
module tb_serial_frame_controller;
    localparam int PEN = 1;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    serial_frame_controller_if bus();
    serial_frame_controller #(.PARITY_EN(PEN)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // external shift register: first received bit ends up at sh_q[5]
    always @(posedge clk) begin
        if (bus.sh_en) begin
            bus.sh_q[1:5] <= bus.sh_q[0:4];
            bus.sh_q[0]   <= bus.serIn;
        end
    end
    // frame description written by the stimulus, consumed by the model
    int         e0 = -100;
    logic [5:0] f_word = 6'd0;
    logic       f_perr = 1'b0;
    logic       f_stop = 1'b1;
    int         cyc = 0;
    int         last_rst = -1;
    logic       armed = 1'b0;
    logic [5:0] m_word;
    logic       m_valid, m_perr, m_ferr, m_ovr;
    wire        f_live = e0 > last_rst;
    wire        at_stop = f_live && (cyc + 1 == e0 + (PEN != 0 ? 8 : 7));
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            armed    <= 1'b1;
            last_rst <= cyc + 1;
            m_word   <= 6'd0;
            m_valid  <= 1'b0;
            m_perr   <= 1'b0;
            m_ferr   <= 1'b0;
            m_ovr    <= 1'b0;
        end else begin
            m_ferr <= at_stop && !f_stop;
            m_ovr  <= at_stop && f_stop && m_valid && !bus.out_ready;
            if (at_stop && f_stop && (!m_valid || bus.out_ready)) begin
                m_word  <= f_word;
                m_perr  <= f_perr;
                m_valid <= 1'b1;
            end else if (m_valid && bus.out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
    wire m_shen = !rst && f_live && cyc >= e0 && cyc <= e0 + 5;
    int   shen_cnt = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (armed) begin
            chk("cycle", {4'd0, bus.out_valid, bus.out_perr, bus.frame_err, bus.overrun, bus.sh_en, bus.sh_in, bus.out_word},
                         {4'd0, m_valid, m_perr, m_ferr, m_ovr, m_shen, bus.serIn, m_word});
            if (bus.sh_en) shen_cnt <= shen_cnt + 1;
            if (bus.out_valid && !prev_valid) rise_cyc <= cyc;
            prev_valid <= bus.out_valid;
        end
    end
    task automatic send_frame(input logic [5:0] d, input logic p, input logic s, input logic rdy_stop);
        logic keep;
        keep   = bus.out_ready;
        bus.serIn = 1'b0;
        e0     = cyc + 1;
        f_word = d;
        f_perr = (PEN != 0) ? (^d ^ p) : 1'b0;
        f_stop = s;
        @(negedge clk);
        for (int i = 5; i >= 0; i--) begin
            bus.serIn = d[i];
            @(negedge clk);
        end
        if (PEN != 0) begin
            bus.serIn = p;
            @(negedge clk);
        end
        bus.serIn     = s;
        bus.out_ready = rdy_stop;
        @(negedge clk);
        bus.serIn     = 1'b1;
        bus.out_ready = keep;
    endtask
    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int s0;
        bus.serIn = 1'b1;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_word", {10'd0, bus.out_word}, 16'h0000);
        chk("reset_flags", {12'd0, bus.out_valid, bus.out_perr, bus.frame_err, bus.overrun}, 16'h0000);
        repeat (20) @(negedge clk);
        #1;
        chk("idle_shen_count", shen_cnt[15:0], 16'd0);
        // good frame, parity 1 makes even parity over 1,0,1,1,0,0
        s0 = shen_cnt;
        send_frame(6'b101100, 1'b1, 1'b1, 1'b1);
        #1;
        chk("f1_word", {10'd0, bus.out_word}, 16'h002c);
        chk("f1_valid_perr", {14'd0, bus.out_valid, bus.out_perr}, 16'h0002);
        chk("f1_shen_cycles", 16'(shen_cnt - s0), 16'd6);
        chk("f1_latency", 16'(rise_cyc - e0), 16'd8);
        drain();
        #1;
        chk("f1_accepted", {15'd0, bus.out_valid}, 16'h0000);
        send_frame(6'b101100, 1'b0, 1'b1, 1'b0);
        #1;
        chk("perr_word", {10'd0, bus.out_word}, 16'h002c);
        chk("perr_flag", {15'd0, bus.out_perr}, 16'h0001);
        drain();
        send_frame(6'b110011, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stop_ferr_valid", {14'd0, bus.frame_err, bus.out_valid}, 16'h0002);
        @(negedge clk);
        #1;
        chk("stop_ferr_clear", {15'd0, bus.frame_err}, 16'h0000);
        send_frame(6'b101010, 1'b1, 1'b1, 1'b0);
        send_frame(6'b010101, 1'b1, 1'b1, 1'b0);
        #1;
        chk("ovr_word", {10'd0, bus.out_word}, 16'h002a);
        chk("ovr_pulse_valid", {14'd0, bus.overrun, bus.out_valid}, 16'h0003);
        @(negedge clk);
        #1;
        chk("ovr_pulse_end", {15'd0, bus.overrun}, 16'h0000);
        drain();
        send_frame(6'b101010, 1'b1, 1'b1, 1'b0);
        send_frame(6'b010101, 1'b1, 1'b1, 1'b1);
        #1;
        chk("accdel_word", {10'd0, bus.out_word}, 16'h0015);
        chk("accdel_valid_ovr", {14'd0, bus.out_valid, bus.overrun}, 16'h0002);
        drain();
        // reset after three data bits aborts the frame silently
        bus.serIn = 1'b0;
        e0     = cyc + 1;
        f_word = 6'b111111;
        f_perr = 1'b0;
        f_stop = 1'b1;
        @(negedge clk);
        repeat (3) begin
            bus.serIn = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("rst_cycle_shen", {15'd0, bus.sh_en}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("rst_no_delivery", {15'd0, bus.out_valid}, 16'h0000);
        send_frame(6'b111000, 1'b1, 1'b1, 1'b0);
        #1;
        chk("post_rst_word", {10'd0, bus.out_word}, 16'h0038);
        chk("post_rst_flags", {14'd0, bus.out_valid, bus.out_perr}, 16'h0002);
        drain();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
